// File: rtl/prog_interval_timer.sv
// Programmable interval timer: prescaler base ticks, N-tick one-shot or periodic timeout.
// Define PROG_TIMER_PERIODIC_EN to enable periodic (auto-reload) mode; otherwise one-shot only.
module prog_interval_timer #(
   parameter int unsigned TICK_DIV = 5_000_000,
   parameter int unsigned PRE_W    = 23,
   parameter int unsigned PERIOD_W = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_enable,
   input  logic                i_periodic,
   input  logic [PERIOD_W-1:0] i_period,
   output logic                o_tick,
   output logic                o_time_out,
   output logic                o_busy,
   output logic [PERIOD_W-1:0] o_elapsed
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic [PRE_W-1:0] PreMax = PRE_W'(TICK_DIV - 1);

   state_e              r_state_q, r_state_d;
   logic [PRE_W-1:0]    r_pre_q, r_pre_d;
   logic [PERIOD_W-1:0] r_elapsed_q, r_elapsed_d;
   logic [PERIOD_W-1:0] r_period_q, r_period_d;
   logic                r_mode_q, r_mode_d;
   logic                r_tick_q, r_tick_d;
   logic                r_time_out_q, r_time_out_d;
   logic                r_busy_q, r_busy_d;

   logic [PERIOD_W-1:0] w_period_eff;
   logic [PERIOD_W-1:0] w_elapsed_inc;
   logic                w_mode_in;
   logic                w_wrap;

   // A zero period behaves as one tick.
   assign w_period_eff  = (i_period == '0) ? PERIOD_W'(1) : i_period;
   assign w_elapsed_inc = r_elapsed_q + PERIOD_W'(1);
   assign w_wrap        = (r_pre_q == PreMax);

`ifdef PROG_TIMER_PERIODIC_EN
   assign w_mode_in = i_periodic;
`else
   // Port kept for interface compatibility; mode is forced to one-shot.
   assign w_mode_in = i_periodic & 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state_q    <= StIdle;
         r_pre_q      <= '0;
         r_elapsed_q  <= '0;
         r_period_q   <= '0;
         r_mode_q     <= 1'b0;
         r_tick_q     <= 1'b0;
         r_time_out_q <= 1'b0;
         r_busy_q     <= 1'b0;
      end else begin
         r_state_q    <= r_state_d;
         r_pre_q      <= r_pre_d;
         r_elapsed_q  <= r_elapsed_d;
         r_period_q   <= r_period_d;
         r_mode_q     <= r_mode_d;
         r_tick_q     <= r_tick_d;
         r_time_out_q <= r_time_out_d;
         r_busy_q     <= r_busy_d;
      end
   end

   always_comb begin
      r_state_d    = r_state_q;
      r_pre_d      = r_pre_q;
      r_elapsed_d  = r_elapsed_q;
      r_period_d   = r_period_q;
      r_mode_d     = r_mode_q;
      r_tick_d     = 1'b0;
      r_time_out_d = 1'b0;

      unique case (r_state_q)
         StIdle: begin
            if (i_enable) begin
               r_state_d   = StRun;
               r_pre_d     = '0;
               r_elapsed_d = '0;
               r_period_d  = w_period_eff;
               r_mode_d    = w_mode_in;
            end
         end
         StRun: begin
            if (!i_enable) begin
               // Abort wins over a coincident terminal edge: no pulses.
               r_state_d   = StIdle;
               r_pre_d     = '0;
               r_elapsed_d = '0;
            end else if (w_wrap) begin
               r_pre_d  = '0;
               r_tick_d = 1'b1;
               if (w_elapsed_inc == r_period_q) begin
                  r_time_out_d = 1'b1;
                  if (r_mode_q) begin
                     r_elapsed_d = '0;
                     r_period_d  = w_period_eff;
                  end else begin
                     r_elapsed_d = r_period_q;
                     r_state_d   = StDone;
                  end
               end else begin
                  r_elapsed_d = w_elapsed_inc;
               end
            end else begin
               r_pre_d = r_pre_q + PRE_W'(1);
            end
         end
         StDone: begin
            // Held enable never re-fires; only a drop of enable re-arms.
            if (!i_enable) begin
               r_state_d   = StIdle;
               r_pre_d     = '0;
               r_elapsed_d = '0;
            end
         end
         default: begin
            r_state_d   = StIdle;
            r_pre_d     = '0;
            r_elapsed_d = '0;
         end
      endcase

      r_busy_d = (r_state_d == StRun);
   end

   assign o_tick     = r_tick_q;
   assign o_time_out = r_time_out_q;
   assign o_busy     = r_busy_q;
   assign o_elapsed  = r_elapsed_q;

endmodule

// File: tb/tb_prog_interval_timer.sv
// Bench for prog_interval_timer: cycle-count model checked every cycle, plus directed checks.
module tb_prog_interval_timer;

   localparam int unsigned TickDiv = 4;
`ifdef PROG_TIMER_PERIODIC_EN
   localparam bit PerEn = 1'b1;
`else
   localparam bit PerEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       periodic = 1'b0;
   logic [3:0] period = 4'd0;
   logic       o_tick, o_time_out, o_busy;
   logic [3:0] o_elapsed;

   int n_cmp = 0;
   int n_bad = 0;
   int to_cnt, tick_cnt;
   int to_at[4];

   prog_interval_timer #(
      .TICK_DIV (TickDiv),
      .PRE_W    (2),
      .PERIOD_W (4)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_enable   (enable),
      .i_periodic (periodic),
      .i_period   (period),
      .o_tick     (o_tick),
      .o_time_out (o_time_out),
      .o_busy     (o_busy),
      .o_elapsed  (o_elapsed)
   );

   always #5 clk = ~clk;

   // Model: counts clock edges since the interval started; ticks every TickDiv, timeout at N*TickDiv.
   bit m_run, m_done, m_mode, m_tick, m_to;
   int m_cyc, m_n;

   function automatic int eff(input logic [3:0] p);
      return (p == 4'd0) ? 1 : int'(p);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 0; m_done <= 0; m_mode <= 0; m_tick <= 0; m_to <= 0;
         m_cyc <= 0; m_n <= 0;
      end else begin
         m_tick <= 0;
         m_to   <= 0;
         if (!m_run && !m_done) begin
            if (enable) begin
               m_run  <= 1;
               m_cyc  <= 0;
               m_n    <= eff(period);
               m_mode <= periodic && PerEn;
            end
         end else if (!enable) begin
            m_run <= 0; m_done <= 0; m_cyc <= 0;
         end else if (m_run) begin
            m_cyc <= m_cyc + 1;
            if ((m_cyc + 1) % TickDiv == 0) m_tick <= 1;
            if (m_cyc + 1 == TickDiv * m_n) begin
               m_to <= 1;
               if (m_mode) begin
                  m_cyc <= 0;
                  m_n   <= eff(period);
               end else begin
                  m_run  <= 0;
                  m_done <= 1;
               end
            end
         end
      end
   end

   function automatic int exp_elapsed();
      if (m_done) return m_n;
      if (m_run) return m_cyc / TickDiv;
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         n_cmp++;
         if (o_tick !== m_tick || o_time_out !== m_to || o_busy !== m_run ||
             int'(o_elapsed) != exp_elapsed()) begin
            n_bad++;
            $display("FAIL model t=%0t: tick/to/busy/elapsed got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                     $time, o_tick, o_time_out, o_busy, o_elapsed,
                     m_tick, m_to, m_run, exp_elapsed());
         end
      end
   endtask

   // Caller stands just after a posedge; k=0 is the next edge (E0 when enabling from idle).
   task automatic run_window(input int edges, input int chg_at, input logic [3:0] chg_period,
                             input logic chg_en);
      to_cnt   = 0;
      tick_cnt = 0;
      for (int i = 0; i < 4; i++) to_at[i] = -1;
      for (int k = 0; k <= edges; k++) begin
         @(posedge clk);
         #1;
         if (o_tick) tick_cnt++;
         if (o_time_out) begin
            if (to_cnt < 4) to_at[to_cnt] = k;
            to_cnt++;
         end
         if (k == chg_at) begin
            period = chg_period;
            enable = chg_en;
         end
      end
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         monitor();
      join_none

      #22;
      check("reset busy", int'(o_busy), 0);
      check("reset elapsed", int'(o_elapsed), 0);
      check("reset tick", int'(o_tick), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // One-shot, period 3: ticks at 4/8/12, single timeout at 12, then DONE.
      @(posedge clk);
      #1;
      enable = 1'b1; periodic = 1'b0; period = 4'd3;
      run_window(20, -1, 4'd3, 1'b1);
      check("oneshot ticks", tick_cnt, 3);
      check("oneshot to count", to_cnt, 1);
      check("oneshot to at", to_at[0], 12);
      check("oneshot done busy", int'(o_busy), 0);
      check("oneshot done elapsed", int'(o_elapsed), 3);
      go_idle();
      check("idle elapsed", int'(o_elapsed), 0);

      // Periodic period 2, reloaded to 1 mid-interval: 8, 16, 20 (one-shot only without macro).
      @(posedge clk);
      #1;
      enable = 1'b1; periodic = 1'b1; period = 4'd2;
      run_window(22, 10, 4'd1, 1'b1);
      check("periodic to at0", to_at[0], 8);
      check("periodic to count", to_cnt, PerEn ? 3 : 1);
      check("periodic to at1", to_at[1], PerEn ? 16 : -1);
      check("periodic to at2", to_at[2], PerEn ? 20 : -1);
      check("periodic ticks", tick_cnt, PerEn ? 5 : 2);
      check("periodic busy", int'(o_busy), PerEn ? 1 : 0);
      go_idle();

      // Period zero behaves as one tick.
      @(posedge clk);
      #1;
      enable = 1'b1; periodic = 1'b0; period = 4'd0;
      run_window(10, -1, 4'd0, 1'b1);
      check("zero to at", to_at[0], 4);
      check("zero to count", to_cnt, 1);
      check("zero elapsed", int'(o_elapsed), 1);
      go_idle();

      // Abort just before the terminal edge, then a full re-run.
      @(posedge clk);
      #1;
      enable = 1'b1; period = 4'd3;
      run_window(14, 11, 4'd3, 1'b0);
      check("abort to count", to_cnt, 0);
      check("abort ticks", tick_cnt, 2);
      check("abort busy", int'(o_busy), 0);
      check("abort elapsed", int'(o_elapsed), 0);
      enable = 1'b1;
      run_window(14, -1, 4'd3, 1'b1);
      check("rerun to at", to_at[0], 12);
      go_idle();

      // Async reset mid-run clears outputs without a clock edge.
      @(posedge clk);
      #1;
      enable = 1'b1; period = 4'd3;
      run_window(4, -1, 4'd3, 1'b1);
      check("pre-reset tick", int'(o_tick), 1);
      check("pre-reset elapsed", int'(o_elapsed), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async tick", int'(o_tick), 0);
      check("async busy", int'(o_busy), 0);
      check("async elapsed", int'(o_elapsed), 0);
      @(posedge clk);
      #1;
      enable = 1'b0;
      rst_n  = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
